// File: rtl/multicycle_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_sequencer_if                                                    |
// | Control/handshake bundle between the multicycle sequencer and datapath.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             halt_req;
  logic             mem_ready;
  logic             wb_en_in;
  logic             mem_r_en_in;
  logic             mem_w_en_in;
  logic [1:0]       branch_type_in;
  logic             br_cond;
  logic [2:0]       state;
  logic             imem_req;
  logic             ir_we;
  logic             pc_we;
  logic             pc_sel_branch;
  logic             alu_out_we;
  logic             dmem_rd;
  logic             dmem_wr;
  logic             rf_we;
  logic             instr_done;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  run, halt_req, mem_ready, wb_en_in, mem_r_en_in, mem_w_en_in,
           branch_type_in, br_cond,
    output state, imem_req, ir_we, pc_we, pc_sel_branch, alu_out_we,
           dmem_rd, dmem_wr, rf_we, instr_done, halted, cycle_cnt, instr_cnt
  );

  modport slave (
    output run, halt_req, mem_ready, wb_en_in, mem_r_en_in, mem_w_en_in,
           branch_type_in, br_cond,
    input  state, imem_req, ir_we, pc_we, pc_sel_branch, alu_out_we,
           dmem_rd, dmem_wr, rf_we, instr_done, halted, cycle_cnt, instr_cnt
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_sequencer                                                       |
// | FETCH/DECODE/EXEC/MEM/WB control FSM; optional perf counters behind the    |
// | SEQ_PERF_CNT_EN macro.                                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_sequencer #(
  parameter int CNT_W = 32
) (
  input  wire                    clk,
  input  wire                    rst,
  multicycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t state_q;
  state_t state_d;

  logic   w_nop;
  logic   w_taken;
  state_t w_boundary;
  logic   w_out_en;

  logic   w_imem_req;
  logic   w_ir_we;
  logic   w_pc_we;
  logic   w_pc_sel_branch;
  logic   w_alu_out_we;
  logic   w_dmem_rd;
  logic   w_dmem_wr;
  logic   w_rf_we;
  logic   w_instr_done;
  logic   w_halted;

  assign w_nop      = !bus.wb_en_in && !bus.mem_r_en_in && !bus.mem_w_en_in &&
                      (bus.branch_type_in == 2'b00);
  assign w_taken    = (bus.branch_type_in == 2'b11) ||
                      ((bus.branch_type_in != 2'b00) && bus.br_cond);
  assign w_boundary = bus.halt_req ? S_HALT : S_FETCH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    w_imem_req      = 1'b0;
    w_ir_we         = 1'b0;
    w_pc_we         = 1'b0;
    w_pc_sel_branch = 1'b0;
    w_alu_out_we    = 1'b0;
    w_dmem_rd       = 1'b0;
    w_dmem_wr       = 1'b0;
    w_rf_we         = 1'b0;
    w_instr_done    = 1'b0;
    w_halted        = 1'b0;
    case (state_q)
      S_FETCH: begin
        w_imem_req = bus.run;
        if (bus.run && bus.mem_ready) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_nop) begin
          w_instr_done = 1'b1;
          state_d      = w_boundary;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        w_alu_out_we = 1'b1;
        if (w_taken) begin
          w_pc_we         = 1'b1;
          w_pc_sel_branch = 1'b1;
        end
        // Branches always retire here, taken or not.
        if (bus.branch_type_in != 2'b00) begin
          w_instr_done = 1'b1;
          state_d      = w_boundary;
        end else if (bus.mem_r_en_in || bus.mem_w_en_in) begin
          state_d = S_MEM;
        end else if (bus.wb_en_in) begin
          state_d = S_WB;
        end else begin
          w_instr_done = 1'b1;
          state_d      = w_boundary;
        end
      end
      S_MEM: begin
        w_dmem_rd = bus.mem_r_en_in;
        w_dmem_wr = bus.mem_w_en_in && !bus.mem_r_en_in;
        if (bus.mem_ready) begin
          if (bus.mem_r_en_in) begin
            state_d = S_WB;
          end else begin
            w_instr_done = 1'b1;
            state_d      = w_boundary;
          end
        end
      end
      S_WB: begin
        w_rf_we      = bus.wb_en_in;
        w_instr_done = 1'b1;
        state_d      = w_boundary;
      end
      S_HALT: begin
        w_halted = 1'b1;
        if (!bus.halt_req) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Outputs are forced low for the whole reset interval, including FETCH's imem_req.
  assign w_out_en = !rst;

  assign bus.state         = w_out_en ? state_q : 3'd0;
  assign bus.imem_req      = w_out_en && w_imem_req;
  assign bus.ir_we         = w_out_en && w_ir_we;
  assign bus.pc_we         = w_out_en && w_pc_we;
  assign bus.pc_sel_branch = w_out_en && w_pc_sel_branch;
  assign bus.alu_out_we    = w_out_en && w_alu_out_we;
  assign bus.dmem_rd       = w_out_en && w_dmem_rd;
  assign bus.dmem_wr       = w_out_en && w_dmem_wr;
  assign bus.rf_we         = w_out_en && w_rf_we;
  assign bus.instr_done    = w_out_en && w_instr_done;
  assign bus.halted        = w_out_en && w_halted;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q;
  logic [CNT_W-1:0] instr_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != S_HALT) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end
    if (w_instr_done) begin
      instr_cnt_d = instr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.instr_cnt = instr_cnt_q;
`else
  assign bus.cycle_cnt = {CNT_W{1'b0}};
  assign bus.instr_cnt = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_sequencer                                                    |
// | Scoreboard bench: per-instruction expectations checked on instr_done.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_sequencer;

  localparam int TB_CNT_W = 32;

  logic clk;
  logic rst;

  multicycle_sequencer_if #(.CNT_W(TB_CNT_W)) bus ();

  multicycle_sequencer #(.CNT_W(TB_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       nm;
    int          lat;
    logic [23:0] trace;
    int          rf;
    int          rd;
    int          wr;
    int          br;
    int          pcw;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   dwait = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Data memory model: dwait stall cycles per data access, instruction fetch is zero-wait.
  int waited = 0;
  initial bus.mem_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (bus.dmem_rd || bus.dmem_wr) begin
      if (waited < dwait) begin
        bus.mem_ready = 1'b0;
        waited++;
      end else begin
        bus.mem_ready = 1'b1;
      end
    end else begin
      bus.mem_ready = 1'b1;
      waited = 0;
    end
  end

  // Monitor: accumulate per-instruction activity from IR latch to retirement.
  bit          active = 0;
  int          m_cyc, m_rf, m_rd, m_wr, m_br, m_pcw;
  logic [23:0] m_trace;
  exp_t        e;
  always @(negedge clk) begin
    if (rst) begin
      active = 0;
    end else begin
      if (bus.ir_we) begin
        active = 1; m_cyc = 0; m_trace = '0;
        m_rf = 0; m_rd = 0; m_wr = 0; m_br = 0; m_pcw = 0;
      end
      if (active) begin
        m_cyc++;
        m_trace = {m_trace[20:0], bus.state};
        m_rf  += int'(bus.rf_we);
        m_rd  += int'(bus.dmem_rd);
        m_wr  += int'(bus.dmem_wr);
        m_br  += int'(bus.pc_we && bus.pc_sel_branch);
        m_pcw += int'(bus.pc_we);
        if (bus.instr_done) begin
          active = 0;
          if (sb.size() == 0) begin
            chk("unexpected_retire", 1, 0);
          end else begin
            e = sb.pop_front();
            chk({e.nm, "_lat"},   m_cyc,   e.lat);
            chk({e.nm, "_trace"}, m_trace, e.trace);
            chk({e.nm, "_rf_we"}, m_rf,    e.rf);
            chk({e.nm, "_rd"},    m_rd,    e.rd);
            chk({e.nm, "_wr"},    m_wr,    e.wr);
            chk({e.nm, "_br"},    m_br,    e.br);
            chk({e.nm, "_pc_we"}, m_pcw,   e.pcw);
          end
        end
      end
    end
  end

  function automatic int outs_nonzero();
    return (|{bus.state, bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_sel_branch,
              bus.alu_out_we, bus.dmem_rd, bus.dmem_wr, bus.rf_we,
              bus.instr_done, bus.halted, bus.cycle_cnt, bus.instr_cnt}) ? 1 : 0;
  endfunction

  task automatic set_instr(input logic wb, input logic mr, input logic mw,
                           input logic [1:0] bt, input logic brc, input int dw);
    bus.wb_en_in       = wb;
    bus.mem_r_en_in    = mr;
    bus.mem_w_en_in    = mw;
    bus.branch_type_in = bt;
    bus.br_cond        = brc;
    dwait              = dw;
    bus.run            = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    bit got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.instr_done) begin
        got = 1;
        break;
      end
    end
    if (!got) chk({nm, "_timeout"}, 0, 1);
    @(posedge clk);
    #2;
    bus.run = 1'b0;
  endtask

  // Called at +2 after a rising edge with the FSM sitting in FETCH.
  task automatic issue(input string nm, input logic wb, input logic mr, input logic mw,
                       input logic [1:0] bt, input logic brc, input int dw,
                       input int lat, input logic [23:0] tr, input int rf, input int rd,
                       input int wr, input int br, input int pcw);
    exp_t x;
    x.nm = nm; x.lat = lat; x.trace = tr; x.rf = rf; x.rd = rd;
    x.wr = wr; x.br = br; x.pcw = pcw;
    sb.push_back(x);
    set_instr(wb, mr, mw, bt, brc, dw);
    wait_done(nm);
  endtask

  logic [TB_CNT_W-1:0] exp_cyc;
  logic [TB_CNT_W-1:0] exp_ins;

  initial begin
    rst          = 1'b1;
    bus.halt_req = 1'b0;
    set_instr(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", outs_nonzero(), 0);
    @(posedge clk);
    #2;
    bus.run = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    chk("idle_state", bus.state, 0);
    chk("idle_ir_we_ignores_ready", bus.ir_we, 0);
    @(posedge clk);
    #2;

    // Trace digits (octal) are the state per cycle, oldest first.
    issue("add",      1, 0, 0, 2'b00, 0, 0, 4, 24'o0124,     1, 0, 0, 0, 1);
    issue("ld_wait3", 1, 1, 0, 2'b00, 0, 3, 8, 24'o01233334, 1, 4, 0, 0, 1);
    issue("bez_tkn",  0, 0, 0, 2'b01, 1, 0, 3, 24'o012,      0, 0, 0, 1, 2);
    issue("bez_not",  0, 0, 0, 2'b01, 0, 0, 3, 24'o012,      0, 0, 0, 0, 1);
    issue("nop",      0, 0, 0, 2'b00, 0, 0, 2, 24'o01,       0, 0, 0, 0, 1);
    issue("st",       0, 0, 1, 2'b00, 0, 0, 4, 24'o0123,     0, 0, 1, 0, 1);
    issue("st_wait2", 0, 0, 1, 2'b00, 0, 2, 6, 24'o012333,   0, 0, 3, 0, 1);
    issue("jmp_wb",   1, 0, 0, 2'b11, 0, 0, 3, 24'o012,      0, 0, 0, 1, 2);
    issue("bne_tkn",  0, 1, 0, 2'b10, 1, 0, 3, 24'o012,      0, 0, 0, 1, 2);
    issue("ld_st",    0, 1, 1, 2'b00, 0, 1, 6, 24'o012334,   0, 2, 0, 0, 1);

    // Halt request raised in EXEC of a store and held past the boundary.
    begin
      exp_t x;
      x.nm = "st_halt"; x.lat = 4; x.trace = 24'o0123; x.rf = 0; x.rd = 0;
      x.wr = 1; x.br = 0; x.pcw = 1;
      sb.push_back(x);
    end
    set_instr(0, 0, 1, 2'b00, 0, 0);
    repeat (2) begin @(posedge clk); #2; end
    bus.halt_req = 1'b1;
    wait_done("st_halt");
    bus.run = 1'b1;
    @(negedge clk);
    chk("halt_state", bus.state, 5);
    chk("halt_halted", bus.halted, 1);
    chk("halt_no_imem_req", bus.imem_req, 0);
    chk("halt_no_strobes", |{bus.ir_we, bus.pc_we, bus.alu_out_we, bus.dmem_rd,
                             bus.dmem_wr, bus.rf_we, bus.instr_done}, 0);
    @(posedge clk);
    #2;
    bus.halt_req = 1'b0;
    bus.run      = 1'b0;
    @(negedge clk);
    chk("halt_hold_while_req_drops", bus.state, 5);
    @(posedge clk);
    @(negedge clk);
    chk("halt_exit_fetch", bus.state, 0);
    chk("halt_exit_halted_low", bus.halted, 0);
    @(posedge clk);
    #2;

    // Asynchronous reset while a store is stalled in MEM.
    set_instr(0, 0, 1, 2'b00, 0, 10);
    repeat (3) begin @(posedge clk); #2; end
    @(negedge clk);
    chk("mem_stall_dmem_wr", bus.dmem_wr, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_outputs_zero", outs_nonzero(), 0);
    @(negedge clk);
    @(posedge clk);
    #2;
    bus.run = 1'b0;
    dwait   = 0;
    rst     = 1'b0;
    @(negedge clk);
    chk("post_rst_state", bus.state, 0);
    @(posedge clk);
    #2;

    // Ten back-to-back zero-wait NOPs from a fresh reset.
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      issue("nop_burst", 0, 0, 0, 2'b00, 0, 0, 2, 24'o01, 0, 0, 0, 0, 1);
    end
`ifdef SEQ_PERF_CNT_EN
    exp_cyc = TB_CNT_W'(20);
    exp_ins = TB_CNT_W'(10);
`else
    exp_cyc = '0;
    exp_ins = '0;
`endif
    chk("cycle_cnt", bus.cycle_cnt, exp_cyc);
    chk("instr_cnt", bus.instr_cnt, exp_ins);

    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
